// File: rtl/comm_slave_if.sv
// comm_slave_if: bundles the serial lines and the command/response handshake
// of comm_slave.
//   RX          serial in to the slave, 8N1, idle high
//   TX          serial out from the slave, 8N1, idle high
//   cmd         last complete 16-bit command (high byte received first)
//   cmd_rdy     level, a new cmd is valid
//   clr_cmd_rdy request to clear cmd_rdy
//   overrun     one-cycle pulse, command completed while cmd_rdy was high
//   resp        response byte to transmit
//   send_resp   one-cycle request to transmit resp
//   tx_busy     transmitter active
//   resp_sent   one-cycle pulse at end of the response stop bit
interface comm_slave_if;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        overrun;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;

  modport slave (
    input  RX, clr_cmd_rdy, resp, send_resp,
    output TX, cmd, cmd_rdy, overrun, tx_busy, resp_sent
  );

  modport master (
    output RX, clr_cmd_rdy, resp, send_resp,
    input  TX, cmd, cmd_rdy, overrun, tx_busy, resp_sent
  );
endinterface

// File: rtl/comm_slave.sv
// comm_slave: full-duplex UART command slave.
// Receives two-byte commands (high byte first) on bus.RX and presents them on
// bus.cmd with a cmd_rdy level flag; transmits single response bytes on
// bus.TX on request.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  comm_slave_if.slave (serial lines, command and response handshake)
// Parameters:
//   BAUD_DIV      clocks per UART bit (minimum 8)
//   TIMEOUT_CLKS  max clocks the assembler waits for the low byte
module comm_slave #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_CLKS = 65536
) (
  input  logic         clk,
  input  logic         rst,
  comm_slave_if.slave  bus
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic       {WAIT_HIGH, WAIT_LOW}             asm_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // ---------------- RX synchronizer and edge history ----------------
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= bus.RX;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // ---------------- Receiver ----------------
  rx_state_t       rx_state_reg, rx_state_next;
  logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
  logic [2:0]      rx_bit_reg, rx_bit_next;
  logic [7:0]      rx_shift_reg, rx_shift_next;
  logic            rx_good_reg, rx_good_next;
  logic            rx_ferr_reg, rx_ferr_next;
  // After reset the synchronizer's forced 1 is not a real idle line. Start
  // edges are only honoured once RX has actually been seen high for a full
  // bit time, so a frame already in flight at reset release is ignored.
  logic            armed_reg, armed_next;
  logic [CW-1:0]   arm_cnt_reg, arm_cnt_next;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_good_next  = 1'b0;
    rx_ferr_next  = 1'b0;
    armed_next    = armed_reg;
    arm_cnt_next  = arm_cnt_reg;

    if (!armed_reg) begin
      if (rx_sync_reg) begin
        if (arm_cnt_reg == BIT_LAST) armed_next = 1'b1;
        else                         arm_cnt_next = arm_cnt_reg + 1'b1;
      end else begin
        arm_cnt_next = '0;
      end
    end

    case (rx_state_reg)
      R_IDLE: begin
        if (armed_reg && rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = R_START;
          rx_cnt_next   = '0;
        end
      end
      R_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          // High at mid-start is a glitch, not a frame.
          rx_state_next = rx_sync_reg ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) rx_state_next = R_STOP;
          else                    rx_bit_next   = rx_bit_reg + 1'b1;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = R_IDLE;
          rx_good_next  = rx_sync_reg;
          rx_ferr_next  = !rx_sync_reg;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg <= R_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_good_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
      armed_reg    <= 1'b0;
      arm_cnt_reg  <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_good_reg  <= rx_good_next;
      rx_ferr_reg  <= rx_ferr_next;
      armed_reg    <= armed_next;
      arm_cnt_reg  <= arm_cnt_next;
    end
  end

  // ---------------- Command assembler ----------------
  asm_state_t    asm_state_reg, asm_state_next;
  logic [7:0]    high_reg, high_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [15:0]   cmd_reg, cmd_next;
  logic          cmd_rdy_reg, cmd_rdy_next;
  logic          overrun_reg, overrun_next;

  // rx_shift_reg is stable while rx_good_reg pulses: it only shifts during
  // the data bits of the following frame.
  always_comb begin
    asm_state_next = asm_state_reg;
    high_next      = high_reg;
    to_cnt_next    = to_cnt_reg;
    cmd_next       = cmd_reg;
    cmd_rdy_next   = cmd_rdy_reg;
    overrun_next   = 1'b0;

    if (bus.clr_cmd_rdy) cmd_rdy_next = 1'b0;

    case (asm_state_reg)
      WAIT_HIGH: begin
        if (rx_good_reg) begin
          high_next      = rx_shift_reg;
          to_cnt_next    = '0;
          asm_state_next = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // Completion is checked before timeout so it wins a tie; a set
        // from completion likewise overrides a simultaneous clear.
        if (rx_good_reg) begin
          cmd_next       = {high_reg, rx_shift_reg};
          cmd_rdy_next   = 1'b1;
          overrun_next   = cmd_rdy_reg;
          asm_state_next = WAIT_HIGH;
        end else if (rx_ferr_reg || to_cnt_reg == TO_LAST) begin
          high_next      = '0;
          asm_state_next = WAIT_HIGH;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      default: asm_state_next = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state_reg <= WAIT_HIGH;
      high_reg      <= '0;
      to_cnt_reg    <= '0;
      cmd_reg       <= '0;
      cmd_rdy_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      asm_state_reg <= asm_state_next;
      high_reg      <= high_next;
      to_cnt_reg    <= to_cnt_next;
      cmd_reg       <= cmd_next;
      cmd_rdy_reg   <= cmd_rdy_next;
      overrun_reg   <= overrun_next;
    end
  end

  // ---------------- Transmitter ----------------
  tx_state_t     tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          tx_reg, tx_next;
  logic          tx_busy_reg, tx_busy_next;
  logic          resp_sent_reg, resp_sent_next;

  always_comb begin
    tx_state_next  = tx_state_reg;
    tx_cnt_next    = tx_cnt_reg;
    tx_bit_next    = tx_bit_reg;
    tx_shift_next  = tx_shift_reg;
    tx_next        = tx_reg;
    tx_busy_next   = tx_busy_reg;
    resp_sent_next = 1'b0;

    case (tx_state_reg)
      T_IDLE: begin
        // A request coinciding with resp_sent is dropped, not queued.
        if (bus.send_resp && !resp_sent_reg) begin
          tx_shift_next = bus.resp;
          tx_next       = 1'b0;
          tx_busy_next  = 1'b1;
          tx_cnt_next   = '0;
          tx_state_next = T_START;
        end
      end
      T_START: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_next       = tx_shift_reg[0];
          tx_state_next = T_DATA;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      T_DATA: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == 3'd7) begin
            tx_next       = 1'b1;
            tx_state_next = T_STOP;
          end else begin
            tx_bit_next   = tx_bit_reg + 1'b1;
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            tx_next       = tx_shift_reg[1];
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      T_STOP: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next    = '0;
          tx_busy_next   = 1'b0;
          resp_sent_next = 1'b1;
          tx_state_next  = T_IDLE;
        end else begin
          tx_cnt_next = tx_cnt_reg + 1'b1;
        end
      end
      default: tx_state_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg  <= T_IDLE;
      tx_cnt_reg    <= '0;
      tx_bit_reg    <= '0;
      tx_shift_reg  <= '0;
      tx_reg        <= 1'b1;
      tx_busy_reg   <= 1'b0;
      resp_sent_reg <= 1'b0;
    end else begin
      tx_state_reg  <= tx_state_next;
      tx_cnt_reg    <= tx_cnt_next;
      tx_bit_reg    <= tx_bit_next;
      tx_shift_reg  <= tx_shift_next;
      tx_reg        <= tx_next;
      tx_busy_reg   <= tx_busy_next;
      resp_sent_reg <= resp_sent_next;
    end
  end

  assign bus.TX        = tx_reg;
  assign bus.tx_busy   = tx_busy_reg;
  assign bus.resp_sent = resp_sent_reg;
  assign bus.cmd       = cmd_reg;
  assign bus.cmd_rdy   = cmd_rdy_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_comm_slave.sv
// tb_comm_slave: self-checking bench for comm_slave (BAUD_DIV=16,
// TIMEOUT_CLKS=400). Directed scenarios plus randomized byte streams are
// checked against a frame-level reference model of command assembly and a
// bit-list model of the transmitted frame.
module tb_comm_slave;
  localparam int BD = 16;
  localparam int TO = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comm_slave_if bus();
  comm_slave #(.BAUD_DIV(BD), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     checks = 0;
  int     errors = 0;
  int     ov_cnt = 0;
  int     rs_cnt = 0;
  longint cyc    = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.overrun)   ov_cnt++;
    if (bus.resp_sent) rs_cnt++;
  end

  // Reference model: commands as pairs of good bytes whose ends lie less
  // than TO clocks apart; a bad frame drops any pending high byte.
  bit          m_have_high = 0;
  logic [7:0]  m_high = '0;
  longint      m_high_end = 0;
  logic [15:0] m_cmd = '0;
  logic        m_rdy = 1'b0;
  int          m_ov = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good, input longint t_end);
    if (!good) begin
      m_have_high = 0;
    end else if (m_have_high && (t_end - m_high_end) < TO) begin
      if (m_rdy) m_ov++;
      m_cmd       = {m_high, b};
      m_rdy       = 1'b1;
      m_have_high = 0;
    end else begin
      m_have_high = 1;
      m_high      = b;
      m_high_end  = t_end;
    end
  endtask

  // Drive one 8N1 frame on RX, update the model, compare cmd/cmd_rdy/overrun.
  task automatic uart_send(input logic [7:0] b, input bit good);
    longint t_end;
    bus.RX = 1'b0;
    tick(BD);
    for (int k = 0; k < 8; k++) begin
      bus.RX = b[k];
      tick(BD);
    end
    check("rdy_before_stop", bus.cmd_rdy, m_rdy);
    bus.RX = good;
    tick(BD);
    t_end = cyc;
    if (!good) begin
      bus.RX = 1'b1;
      tick(BD);
    end
    model_byte(b, good, t_end);
    $display("rx byte %02h stop %0d -> cmd %04h rdy %0d", b, good, bus.cmd, bus.cmd_rdy);
    check("cmd", bus.cmd, m_cmd);
    check("cmd_rdy", bus.cmd_rdy, m_rdy);
    check("overrun_count", ov_cnt, m_ov);
  endtask

  task automatic clear_rdy();
    bus.clr_cmd_rdy = 1'b1;
    tick(1);
    bus.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    check("cmd_rdy_cleared", bus.cmd_rdy, 1'b0);
  endtask

  // Request a response and check every bit centre, busy and resp_sent timing.
  task automatic tx_frame(input logic [7:0] b, input bit poke50, input bit poke_end);
    int   first_rs = -1;
    int   rs0 = rs_cnt;
    logic exp_bit;
    bus.resp = b;
    bus.send_resp = 1'b1;
    tick(1);
    bus.send_resp = 1'b0;
    bus.resp = ~b;
    check("tx_start_low", bus.TX, 1'b0);
    check("tx_busy_set", bus.tx_busy, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (i % 16 == 8 && i < 160) begin
        if (i / 16 == 0)      exp_bit = 1'b0;
        else if (i / 16 == 9) exp_bit = 1'b1;
        else                  exp_bit = b[i / 16 - 1];
        check("tx_bit", bus.TX, exp_bit);
      end
      if (poke50 && i == 50) begin
        bus.resp = 8'hFF;
        bus.send_resp = 1'b1;
      end else if (i == 51 || (first_rs >= 0 && i == first_rs + 1)) begin
        bus.send_resp = 1'b0;
      end
      if (bus.resp_sent && first_rs < 0) begin
        first_rs = i;
        if (poke_end) bus.send_resp = 1'b1;
      end
      tick(1);
    end
    $display("tx byte %02h resp_sent at %0d clocks", b, first_rs);
    check("resp_sent_time", first_rs, 160);
    check("resp_sent_count", rs_cnt - rs0, 1);
    check("tx_idle_high", bus.TX, 1'b1);
    check("tx_busy_clear", bus.tx_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    bus.RX = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp = '0;
    bus.send_resp = 1'b0;
    tick(5);
    check("reset_TX", bus.TX, 1'b1);
    check("reset_cmd", bus.cmd, 16'h0000);
    check("reset_cmd_rdy", bus.cmd_rdy, 1'b0);
    check("reset_overrun", bus.overrun, 1'b0);
    check("reset_tx_busy", bus.tx_busy, 1'b0);
    check("reset_resp_sent", bus.resp_sent, 1'b0);
    rst = 1'b0;
    tick(40);

    // Basic command and clear.
    uart_send(8'hA5, 1);
    uart_send(8'h3C, 1);
    check("cmd_A53C", bus.cmd, 16'hA53C);
    clear_rdy();

    // Response 0x5A with an ignored second request at clock 50, then a
    // request coinciding with resp_sent.
    tx_frame(8'h5A, 1, 0);
    tx_frame(8'hC6, 0, 1);

    // High byte timeout.
    uart_send(8'h12, 1);
    tick(500);
    uart_send(8'h34, 1);
    uart_send(8'h56, 1);
    check("cmd_after_timeout", bus.cmd, 16'h3456);
    clear_rdy();

    // Overrun, then a short glitch followed by a clean command.
    uart_send(8'h01, 1);
    uart_send(8'h02, 1);
    uart_send(8'h03, 1);
    uart_send(8'h04, 1);
    check("cmd_0304", bus.cmd, 16'h0304);
    check("overrun_once", ov_cnt, 1);
    bus.RX = 1'b0;
    tick(4);
    bus.RX = 1'b1;
    tick(100);
    clear_rdy();
    uart_send(8'hAA, 1);
    uart_send(8'h55, 1);
    check("cmd_after_glitch", bus.cmd, 16'hAA55);
    clear_rdy();

    // Framing error on the low byte.
    uart_send(8'h12, 1);
    uart_send(8'h77, 0);
    check("no_rdy_bad_frame", bus.cmd_rdy, 1'b0);
    uart_send(8'h34, 1);
    uart_send(8'h56, 1);
    check("cmd_after_ferr", bus.cmd, 16'h3456);

    // Randomized byte stream with gaps either side of the timeout.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(3) == 0) tick($urandom_range(300, 380));
      else                        tick($urandom_range(1, 150));
      rb = 8'($urandom);
      uart_send(rb, $urandom_range(5) != 0);
      if ($urandom_range(3) == 0) clear_rdy();
    end

    // Full duplex: a response frame while a command is received.
    clear_rdy();
    fork
      tx_frame(8'($urandom), 0, 0);
      begin
        uart_send(8'h9C, 1);
        uart_send(8'h3E, 1);
      end
    join
    check("cmd_duplex", bus.cmd, 16'h9C3E);

    // Reset in the middle of both directions.
    bus.resp = 8'hC3;
    bus.send_resp = 1'b1;
    tick(1);
    bus.send_resp = 1'b0;
    bus.RX = 1'b0;
    tick(BD);
    bus.RX = 1'b1;
    tick(BD);
    bus.RX = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    check("midrst_TX", bus.TX, 1'b1);
    check("midrst_cmd", bus.cmd, 16'h0000);
    check("midrst_cmd_rdy", bus.cmd_rdy, 1'b0);
    check("midrst_overrun", bus.overrun, 1'b0);
    check("midrst_tx_busy", bus.tx_busy, 1'b0);
    check("midrst_resp_sent", bus.resp_sent, 1'b0);
    tick(2);
    bus.RX = 1'b1;
    rst = 1'b0;
    m_have_high = 0;
    m_cmd = '0;
    m_rdy = 1'b0;
    tick(60);
    check("postrst_TX_idle", bus.TX, 1'b1);
    uart_send(8'hBE, 1);
    uart_send(8'hEF, 1);
    check("cmd_BEEF", bus.cmd, 16'hBEEF);
    check("rdy_BEEF", bus.cmd_rdy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/comm_slave.md
COMM_SLAVE -- requirements
Module: comm_slave

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per UART bit (19200 baud at 50 MHz); legal minimum 8.
REQ-002 Parameter TIMEOUT_CLKS, default 65536, maximum clocks allowed between end of high byte and end of low byte.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 RX  input  1  asynchronous serial in, 8N1, idle high.
REQ-006 TX  output  1  serial out, 8N1, idle high.
REQ-007 cmd  output  16  last complete command, high byte first on the line.
REQ-008 cmd_rdy  output  1  level; a new cmd is valid.
REQ-009 clr_cmd_rdy  input  1  clears cmd_rdy.
REQ-010 overrun  output  1  one-cycle pulse; a command completed while cmd_rdy was already high.
REQ-011 resp  input  8  response byte to send.
REQ-012 send_resp  input  1  one-cycle request to transmit resp.
REQ-013 tx_busy  output  1  transmitter active.
REQ-014 resp_sent  output  1  one-cycle pulse at end of response stop bit.

Function
REQ-015 RX SHALL pass through a two-flop synchronizer reset to 1; all receive logic SHALL use the synchronized value only.
REQ-016 Receiver states SHALL be R_IDLE, R_START, R_DATA, R_STOP.
REQ-017 R_IDLE -> R_START on a 1-to-0 transition of synchronized RX.
REQ-018 R_START SHALL resample after BAUD_DIV/2 clocks; if RX is high (false start), return to R_IDLE with no byte produced.
REQ-019 R_DATA SHALL sample 8 bits, LSB first, every BAUD_DIV clocks after the mid-start sample.
REQ-020 R_STOP SHALL sample BAUD_DIV clocks after bit 7; 1 = good byte, 0 = framing error; either way return to R_IDLE.
REQ-021 Assembler states SHALL be WAIT_HIGH and WAIT_LOW.
REQ-022 Good byte in WAIT_HIGH: store as high byte; go to WAIT_LOW; clear timeout counter.
REQ-023 Good byte in WAIT_LOW: load cmd = {high, byte}; set cmd_rdy; go to WAIT_HIGH.
REQ-024 cmd and cmd_rdy SHALL update on the clock edge after the low byte's stop sample (1-cycle latency).
REQ-025 Framing error in WAIT_LOW SHALL discard the stored high byte and return to WAIT_HIGH.
REQ-026 Framing error in WAIT_HIGH SHALL leave the assembler in WAIT_HIGH.
REQ-027 WAIT_LOW timeout counter SHALL count every clock; on reaching TIMEOUT_CLKS, return to WAIT_HIGH with high byte discarded.
REQ-028 Timeout and low-byte completion on the same cycle: completion SHALL win.
REQ-029 cmd SHALL hold its value until the next complete command.
REQ-030 cmd_rdy SHALL clear on the edge after clr_cmd_rdy.
REQ-031 Completion and clr_cmd_rdy on the same cycle: cmd_rdy SHALL stay 1.
REQ-032 Completion while cmd_rdy=1: cmd SHALL be overwritten, cmd_rdy SHALL stay 1, and overrun SHALL pulse.
REQ-033 Transmitter states SHALL be T_IDLE, T_START, T_DATA, T_STOP.
REQ-034 send_resp in T_IDLE: latch resp; TX low and tx_busy high from the next edge.
REQ-035 Each transmitted bit SHALL last exactly BAUD_DIV clocks: start 0, data LSB first, stop 1.
REQ-036 After the stop bit completes: pulse resp_sent, clear tx_busy, return to T_IDLE; total frame 10*BAUD_DIV clocks.
REQ-037 send_resp while tx_busy=1 SHALL be ignored; the latched byte SHALL be unaffected by resp changes.
REQ-038 send_resp on the same cycle as resp_sent SHALL be ignored.
REQ-039 Receiver and transmitter SHALL operate fully independently (full duplex).

Reset
REQ-040 Reset SHALL force TX=1, cmd=0, cmd_rdy=0, overrun=0, tx_busy=0, resp_sent=0, synchronizer=1, receiver to R_IDLE, assembler to WAIT_HIGH, transmitter to T_IDLE, and all counters to 0.
REQ-041 Reset mid-frame SHALL abort both directions immediately; a partially received byte SHALL be lost.
REQ-042 A command SHALL be accepted only if its high-byte start edge occurs after rst deasserts.

Verification (BAUD_DIV=16, TIMEOUT_CLKS=400)
REQ-043 Drive bytes 0xA5 then 0x3C on RX -> cmd=0xA53C, cmd_rdy=1 one cycle after the second stop sample; clr_cmd_rdy -> cmd_rdy=0.
REQ-044 Pulse send_resp with resp=0x5A -> TX shows 0,0,1,0,1,1,0,1,0,1 at 16 clocks/bit; resp_sent pulses 160 clocks after the first TX low; second send_resp at clock 50 is ignored.
REQ-045 Send 0x12, then idle 500 clocks, then send 0x34 and 0x56 -> cmd=0x3456; 0x12 is never seen.
REQ-046 High byte 0x12, then low byte with stop bit 0, then 0x34 and 0x56 -> cmd=0x3456, with no cmd_rdy on the bad frame.
REQ-047 Two commands 0x0102 and 0x0304 without clr_cmd_rdy -> cmd=0x0304, cmd_rdy=1, one overrun pulse; a 4-clock RX glitch low -> no byte produced.
REQ-048 Assert rst mid-transmit and mid-receive -> TX=1 and all outputs at reset values on the next edge; a subsequent clean command 0xBEEF is received correctly.
